// File: rtl/commit_checker.sv
//============================================================================
// Module      : commit_checker
// Description : Lockstep retirement checker for the single-cycle MIPS CPU.
//               An expected-retirement trace is buffered in a FIFO. Each DUT
//               commit is compared against the head entry. The first
//               mismatch is latched, retired instructions are counted, and
//               the run ends in PASS or FAIL.
// Ports       : clk_i/rst_i           clock, synchronous active-high reset
//               exp_*_i, exp_ready_o  expected-trace push (ready/valid)
//               dut_*_i               DUT commit record (no backpressure)
//               halt_i                program end marker
//               done_o/pass_o/fail_o  registered run status
//               err_code_o            0 none,1 PC,2 REG,3 MEM,4 UNDERRUN,5 LEFTOVER
//               err_index_o           commit index of first error
//               commit_cnt_o          commits checked (saturating)
//               fifo_level_o          current FIFO occupancy
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module commit_checker #(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int DEPTH       = 8,
    parameter int MAX_COMMITS = 600,
    parameter int CNT_W       = 16,
    parameter int CHECK_MEM   = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       exp_valid_i,
    output logic                       exp_ready_o,
    input  logic [DATA_W-1:0]          exp_pc_i,
    input  logic                       exp_rd_we_i,
    input  logic [REG_AW-1:0]          exp_rd_i,
    input  logic [DATA_W-1:0]          exp_rd_data_i,
    input  logic                       exp_mem_we_i,
    input  logic [DATA_W-1:0]          exp_mem_addr_i,
    input  logic [DATA_W-1:0]          exp_mem_data_i,
    input  logic                       dut_valid_i,
    input  logic [DATA_W-1:0]          dut_pc_i,
    input  logic                       dut_rd_we_i,
    input  logic [REG_AW-1:0]          dut_rd_i,
    input  logic [DATA_W-1:0]          dut_rd_data_i,
    input  logic                       dut_mem_we_i,
    input  logic [DATA_W-1:0]          dut_mem_addr_i,
    input  logic [DATA_W-1:0]          dut_mem_data_i,
    input  logic                       halt_i,
    output logic                       done_o,
    output logic                       pass_o,
    output logic                       fail_o,
    output logic [2:0]                 err_code_o,
    output logic [CNT_W-1:0]           err_index_o,
    output logic [CNT_W-1:0]           commit_cnt_o,
    output logic [$clog2(DEPTH):0]     fifo_level_o
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = c_AW + 1;
    localparam int c_RW = 4 * DATA_W + REG_AW + 2;

    localparam logic [2:0] c_ERR_NONE     = 3'd0;
    localparam logic [2:0] c_ERR_PC       = 3'd1;
    localparam logic [2:0] c_ERR_REG      = 3'd2;
    localparam logic [2:0] c_ERR_MEM      = 3'd3;
    localparam logic [2:0] c_ERR_UNDERRUN = 3'd4;
    localparam logic [2:0] c_ERR_LEFTOVER = 3'd5;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_RW-1:0]    r_mem [0:DEPTH-1];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_LW-1:0]    r_level;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_err_idx;
    logic [2:0]         r_err_code;
    logic               r_done;
    logic               r_pass;
    logic               r_fail;

    logic [c_RW-1:0]    w_wr_rec;
    logic [DATA_W-1:0]  w_h_pc;
    logic               w_h_rd_we;
    logic [REG_AW-1:0]  w_h_rd;
    logic [DATA_W-1:0]  w_h_rd_data;
    logic               w_h_mem_we;
    logic [DATA_W-1:0]  w_h_mem_addr;
    logic [DATA_W-1:0]  w_h_mem_data;
    logic               w_h_we_n;
    logic               w_d_we_n;
    logic               w_run;
    logic               w_full;
    logic               w_empty;
    logic               w_commit;
    logic               w_mismatch;
    logic               w_match;
    logic               w_pop;
    logic               w_push;
    logic [2:0]         w_cmp_code;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [c_LW-1:0]    w_lvl_after_pop;
    logic [c_LW-1:0]    w_lvl_next;

    assign w_run   = (r_state == ST_RUN);
    assign w_full  = (r_level == c_LW'(DEPTH));
    assign w_empty = (r_level == '0);

    // Held low while reset is asserted so no record is accepted in that cycle.
    assign exp_ready_o = w_run && !w_full && !rst_i;

    assign w_wr_rec = {exp_pc_i, exp_rd_we_i, exp_rd_i, exp_rd_data_i,
                       exp_mem_we_i, exp_mem_addr_i, exp_mem_data_i};
    assign {w_h_pc, w_h_rd_we, w_h_rd, w_h_rd_data,
            w_h_mem_we, w_h_mem_addr, w_h_mem_data} = r_mem[r_rd_ptr];

    // A write to r0 is architecturally a no-op on both sides.
    assign w_h_we_n = w_h_rd_we   && (w_h_rd   != '0);
    assign w_d_we_n = dut_rd_we_i && (dut_rd_i != '0);

    always_comb begin
        w_cmp_code = c_ERR_NONE;
        if (w_empty) begin
            w_cmp_code = c_ERR_UNDERRUN;
        end else if (w_h_pc != dut_pc_i) begin
            w_cmp_code = c_ERR_PC;
        end else if ((w_h_we_n != w_d_we_n) ||
                     (w_h_we_n && w_d_we_n &&
                      ((w_h_rd != dut_rd_i) || (w_h_rd_data != dut_rd_data_i)))) begin
            w_cmp_code = c_ERR_REG;
        end else if ((CHECK_MEM != 0) &&
                     ((w_h_mem_we != dut_mem_we_i) ||
                      (w_h_mem_we && dut_mem_we_i &&
                       ((w_h_mem_addr != dut_mem_addr_i) ||
                        (w_h_mem_data != dut_mem_data_i))))) begin
            w_cmp_code = c_ERR_MEM;
        end
    end

    assign w_commit   = dut_valid_i && w_run;
    assign w_mismatch = w_commit && (w_cmp_code != c_ERR_NONE);
    assign w_match    = w_commit && (w_cmp_code == c_ERR_NONE);
    // Entry is consumed on PC/REG/MEM mismatch too; only underrun has nothing to pop.
    assign w_pop      = w_commit && !w_empty;
    // A failing cycle freezes the FIFO against the same-cycle push as well.
    assign w_push     = exp_valid_i && exp_ready_o && !w_mismatch;

    assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_cnt_next = w_match ? w_cnt_inc : r_cnt;

    assign w_lvl_after_pop = w_pop ? r_level - c_LW'(1) : r_level;

    always_comb begin
        w_lvl_next = r_level;
        case ({w_push, w_pop})
            2'b10:   w_lvl_next = r_level + c_LW'(1);
            2'b01:   w_lvl_next = r_level - c_LW'(1);
            default: w_lvl_next = r_level;
        endcase
    end

    // Trace storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_rec;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_RUN;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_cnt      <= '0;
            r_err_idx  <= '0;
            r_err_code <= c_ERR_NONE;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_fail     <= 1'b0;
        end else if (r_state == ST_RUN) begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_level <= w_lvl_next;
            r_cnt   <= w_cnt_next;

            if (w_mismatch) begin
                r_state    <= ST_FAIL;
                r_done     <= 1'b1;
                r_fail     <= 1'b1;
                r_err_code <= w_cmp_code;
                r_err_idx  <= r_cnt;
            end else if (w_match && (w_cnt_next == CNT_W'(MAX_COMMITS))) begin
                r_state <= ST_PASS;
                r_done  <= 1'b1;
                r_pass  <= 1'b1;
            end else if (halt_i) begin
                // Halt is judged after this cycle's commit has been retired.
                if (w_lvl_after_pop == '0) begin
                    r_state <= ST_PASS;
                    r_done  <= 1'b1;
                    r_pass  <= 1'b1;
                end else begin
                    r_state    <= ST_FAIL;
                    r_done     <= 1'b1;
                    r_fail     <= 1'b1;
                    r_err_code <= c_ERR_LEFTOVER;
                    r_err_idx  <= w_cnt_next;
                end
            end
        end
    end

    assign done_o       = r_done;
    assign pass_o       = r_pass;
    assign fail_o       = r_fail;
    assign err_code_o   = r_err_code;
    assign err_index_o  = r_err_idx;
    assign commit_cnt_o = r_cnt;
    assign fifo_level_o = r_level;

endmodule

`default_nettype wire

// File: tb/tb_commit_checker.sv
//============================================================================
// Module      : tb_commit_checker
// Description : Self-checking bench for commit_checker. Expected status is
//               queued when each cycle's stimulus is applied and compared
//               after the clock edge that produces it.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_commit_checker;

    typedef struct packed {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] rdd;
        logic        mwe;
        logic [31:0] ma;
        logic [31:0] md;
    } rec_t;

    typedef struct {
        string      tag;
        logic       d;
        logic       p;
        logic       f;
        logic [2:0] code;
        int         idx;
        int         cnt;
        int         lvl;
        logic       rdy;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        exp_valid_i;
    logic [31:0] exp_pc_i;
    logic        exp_rd_we_i;
    logic [4:0]  exp_rd_i;
    logic [31:0] exp_rd_data_i;
    logic        exp_mem_we_i;
    logic [31:0] exp_mem_addr_i;
    logic [31:0] exp_mem_data_i;
    logic        dut_valid_i;
    logic [31:0] dut_pc_i;
    logic        dut_rd_we_i;
    logic [4:0]  dut_rd_i;
    logic [31:0] dut_rd_data_i;
    logic        dut_mem_we_i;
    logic [31:0] dut_mem_addr_i;
    logic [31:0] dut_mem_data_i;
    logic        halt_i;

    logic        exp_ready_o, done_o, pass_o, fail_o;
    logic [2:0]  err_code_o;
    logic [15:0] err_index_o, commit_cnt_o;
    logic [3:0]  fifo_level_o;

    logic        nm_ready, nm_done, nm_pass, nm_fail;
    logic [2:0]  nm_code;
    logic [15:0] nm_idx, nm_cnt;
    logic [3:0]  nm_level;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];
    rec_t recs[9];

    always #5 clk_i = ~clk_i;

    commit_checker u_dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .exp_valid_i(exp_valid_i), .exp_ready_o(exp_ready_o),
        .exp_pc_i(exp_pc_i), .exp_rd_we_i(exp_rd_we_i), .exp_rd_i(exp_rd_i),
        .exp_rd_data_i(exp_rd_data_i), .exp_mem_we_i(exp_mem_we_i),
        .exp_mem_addr_i(exp_mem_addr_i), .exp_mem_data_i(exp_mem_data_i),
        .dut_valid_i(dut_valid_i), .dut_pc_i(dut_pc_i), .dut_rd_we_i(dut_rd_we_i),
        .dut_rd_i(dut_rd_i), .dut_rd_data_i(dut_rd_data_i), .dut_mem_we_i(dut_mem_we_i),
        .dut_mem_addr_i(dut_mem_addr_i), .dut_mem_data_i(dut_mem_data_i),
        .halt_i(halt_i), .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o),
        .err_code_o(err_code_o), .err_index_o(err_index_o),
        .commit_cnt_o(commit_cnt_o), .fifo_level_o(fifo_level_o)
    );

    // Second instance that ignores memory fields.
    commit_checker #(.CHECK_MEM(0)) u_dut_nomem (
        .clk_i(clk_i), .rst_i(rst_i),
        .exp_valid_i(exp_valid_i), .exp_ready_o(nm_ready),
        .exp_pc_i(exp_pc_i), .exp_rd_we_i(exp_rd_we_i), .exp_rd_i(exp_rd_i),
        .exp_rd_data_i(exp_rd_data_i), .exp_mem_we_i(exp_mem_we_i),
        .exp_mem_addr_i(exp_mem_addr_i), .exp_mem_data_i(exp_mem_data_i),
        .dut_valid_i(dut_valid_i), .dut_pc_i(dut_pc_i), .dut_rd_we_i(dut_rd_we_i),
        .dut_rd_i(dut_rd_i), .dut_rd_data_i(dut_rd_data_i), .dut_mem_we_i(dut_mem_we_i),
        .dut_mem_addr_i(dut_mem_addr_i), .dut_mem_data_i(dut_mem_data_i),
        .halt_i(halt_i), .done_o(nm_done), .pass_o(nm_pass), .fail_o(nm_fail),
        .err_code_o(nm_code), .err_index_o(nm_idx),
        .commit_cnt_o(nm_cnt), .fifo_level_o(nm_level)
    );

    function automatic rec_t mk(input logic [31:0] pc, input logic we, input logic [4:0] rd,
                                input logic [31:0] rdd, input logic mwe,
                                input logic [31:0] ma, input logic [31:0] md);
        rec_t r;
        r.pc = pc; r.we = we; r.rd = rd; r.rdd = rdd; r.mwe = mwe; r.ma = ma; r.md = md;
        return r;
    endfunction

    function automatic rec_t gen(input int i);
        return mk(32'(4 * i + 4), 1'b1, 5'((i % 31) + 1), 32'(i), 1'b0, 32'h0, 32'h0);
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, req);
        end
    endtask

    task automatic set_exp(input logic v, input rec_t r);
        exp_valid_i = v;      exp_pc_i = r.pc;       exp_rd_we_i = r.we;
        exp_rd_i = r.rd;      exp_rd_data_i = r.rdd; exp_mem_we_i = r.mwe;
        exp_mem_addr_i = r.ma; exp_mem_data_i = r.md;
    endtask

    task automatic set_dut(input logic v, input rec_t r);
        dut_valid_i = v;      dut_pc_i = r.pc;       dut_rd_we_i = r.we;
        dut_rd_i = r.rd;      dut_rd_data_i = r.rdd; dut_mem_we_i = r.mwe;
        dut_mem_addr_i = r.ma; dut_mem_data_i = r.md;
    endtask

    task automatic clear_inputs();
        set_exp(1'b0, '0);
        set_dut(1'b0, '0);
        halt_i = 1'b0;
    endtask

    // Queue the status expected after the next edge, clock, then score it.
    task automatic step(input string tag, input logic d, input logic p, input logic f,
                        input logic [2:0] code, input int idx, input int cnt,
                        input int lvl, input logic rdy);
        exp_t e;
        e.tag = tag; e.d = d; e.p = p; e.f = f; e.code = code;
        e.idx = idx; e.cnt = cnt; e.lvl = lvl; e.rdy = rdy;
        sb_q.push_back(e);
        @(posedge clk_i);
        #1;
        e = sb_q.pop_front();
        check({e.tag, ".done"},  32'(done_o),       32'(e.d));
        check({e.tag, ".pass"},  32'(pass_o),       32'(e.p));
        check({e.tag, ".fail"},  32'(fail_o),       32'(e.f));
        check({e.tag, ".code"},  32'(err_code_o),   32'(e.code));
        check({e.tag, ".idx"},   32'(err_index_o),  32'(e.idx));
        check({e.tag, ".cnt"},   32'(commit_cnt_o), 32'(e.cnt));
        check({e.tag, ".level"}, 32'(fifo_level_o), 32'(e.lvl));
        check({e.tag, ".ready"}, 32'(exp_ready_o),  32'(e.rdy));
    endtask

    task automatic do_reset(input string tag);
        rst_i = 1'b1;
        clear_inputs();
        step(tag, 0, 0, 0, 3'd0, 0, 0, 0, 0);
        rst_i = 1'b0;
        #1;
        check({tag, ".ready_rel"}, 32'(exp_ready_o), 32'd1);
    endtask

    initial begin
        rec_t ra, rb, rc, r1, r2;
        rst_i = 1'b1;
        clear_inputs();
        ra = mk(32'h4,  1'b1, 5'd8, 32'd5, 1'b0, 32'h0, 32'h0);
        rb = mk(32'h8,  1'b0, 5'd0, 32'd0, 1'b1, 32'h4, 32'h7);
        rc = mk(32'h14, 1'b0, 5'd0, 32'd0, 1'b0, 32'h0, 32'h0);
        @(negedge clk_i);

        // Basic pass: three matching commits then halt.
        do_reset("t1.rst");
        set_exp(1'b1, ra); step("t1.push0", 0, 0, 0, 3'd0, 0, 0, 1, 1);
        set_exp(1'b1, rb); step("t1.push1", 0, 0, 0, 3'd0, 0, 0, 2, 1);
        set_exp(1'b1, rc); step("t1.push2", 0, 0, 0, 3'd0, 0, 0, 3, 1);
        set_exp(1'b0, '0);
        set_dut(1'b1, ra); step("t1.cmt0", 0, 0, 0, 3'd0, 0, 1, 2, 1);
        set_dut(1'b1, rb); step("t1.cmt1", 0, 0, 0, 3'd0, 0, 2, 1, 1);
        set_dut(1'b1, rc); step("t1.cmt2", 0, 0, 0, 3'd0, 0, 3, 0, 1);
        set_dut(1'b0, '0); halt_i = 1'b1;
        step("t1.halt", 1, 1, 0, 3'd0, 0, 3, 0, 0);
        halt_i = 1'b0;

        // Register data mismatch on the second commit.
        do_reset("t2.rst");
        r1 = mk(32'h4, 1'b1, 5'd1, 32'd3, 1'b0, 32'h0, 32'h0);
        r2 = mk(32'h8, 1'b1, 5'd2, 32'd6, 1'b0, 32'h0, 32'h0);
        set_exp(1'b1, r1); step("t2.push0", 0, 0, 0, 3'd0, 0, 0, 1, 1);
        set_exp(1'b1, r2); step("t2.push1", 0, 0, 0, 3'd0, 0, 0, 2, 1);
        set_exp(1'b0, '0);
        set_dut(1'b1, r1); step("t2.cmt0", 0, 0, 0, 3'd0, 0, 1, 1, 1);
        r2.rdd = 32'd5;
        set_dut(1'b1, r2); step("t2.bad", 1, 0, 1, 3'd2, 1, 1, 0, 0);
        step("t2.frozen", 1, 0, 1, 3'd2, 1, 1, 0, 0);
        set_dut(1'b0, '0);

        // Underrun with a same-cycle push.
        do_reset("t3.rst");
        set_exp(1'b1, ra); set_dut(1'b1, ra);
        step("t3.under", 1, 0, 1, 3'd4, 0, 0, 0, 0);
        set_dut(1'b0, '0);
        step("t3.frozen", 1, 0, 1, 3'd4, 0, 0, 0, 0);
        set_exp(1'b0, '0);

        // Full FIFO backpressure, no record lost.
        do_reset("t4.rst");
        for (int i = 0; i < 9; i++) recs[i] = mk(32'(4 * i + 4), 1'b1, 5'(i + 1),
                                                 32'(100 + i), 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            set_exp(1'b1, recs[i]);
            step($sformatf("t4.fill%0d", i), 0, 0, 0, 3'd0, 0, 0, i + 1, (i < 7) ? 1'b1 : 1'b0);
        end
        set_exp(1'b1, recs[8]); set_dut(1'b1, recs[0]);
        step("t4.fullpop", 0, 0, 0, 3'd0, 0, 1, 7, 1);
        set_dut(1'b0, '0);
        step("t4.refill", 0, 0, 0, 3'd0, 0, 1, 8, 0);
        set_exp(1'b0, '0);
        for (int k = 1; k < 9; k++) begin
            set_dut(1'b1, recs[k]);
            step($sformatf("t4.drain%0d", k), 0, 0, 0, 3'd0, 0, k + 1, 8 - k, 1);
        end
        set_dut(1'b0, '0); halt_i = 1'b1;
        step("t4.halt", 1, 1, 0, 3'd0, 0, 9, 0, 0);
        halt_i = 1'b0;

        // r0 normalisation and memory-check disable.
        do_reset("t5.rst");
        r1 = mk(32'h4, 1'b0, 5'd0, 32'd0, 1'b0, 32'h0, 32'h0);
        r2 = mk(32'h8, 1'b0, 5'd0, 32'd0, 1'b1, 32'h4, 32'h7);
        set_exp(1'b1, r1); step("t5.push0", 0, 0, 0, 3'd0, 0, 0, 1, 1);
        set_exp(1'b1, r2); step("t5.push1", 0, 0, 0, 3'd0, 0, 0, 2, 1);
        set_exp(1'b0, '0);
        set_dut(1'b1, mk(32'h4, 1'b1, 5'd0, 32'd9, 1'b0, 32'h0, 32'h0));
        step("t5.r0", 0, 0, 0, 3'd0, 0, 1, 1, 1);
        check("t5.nm_cnt0", 32'(nm_cnt), 32'd1);
        set_dut(1'b1, mk(32'h8, 1'b0, 5'd0, 32'd0, 1'b1, 32'h8, 32'h7));
        step("t5.mem", 1, 0, 1, 3'd3, 1, 1, 0, 0);
        check("t5.nm_cnt1", 32'(nm_cnt), 32'd2);
        check("t5.nm_fail", 32'(nm_fail), 32'd0);
        check("t5.nm_code", 32'(nm_code), 32'd0);
        set_dut(1'b0, '0);

        // Halt with entries left over.
        do_reset("t7.rst");
        set_exp(1'b1, ra); step("t7.push0", 0, 0, 0, 3'd0, 0, 0, 1, 1);
        set_exp(1'b1, rb); step("t7.push1", 0, 0, 0, 3'd0, 0, 0, 2, 1);
        set_exp(1'b1, rc); step("t7.push2", 0, 0, 0, 3'd0, 0, 0, 3, 1);
        set_exp(1'b0, '0);
        set_dut(1'b1, ra); halt_i = 1'b1;
        step("t7.halt", 1, 0, 1, 3'd5, 1, 1, 2, 0);
        set_dut(1'b0, '0); halt_i = 1'b0;

        // Reset in the middle of a run, with live inputs that cycle.
        do_reset("t8.rst");
        set_exp(1'b1, ra); step("t8.push0", 0, 0, 0, 3'd0, 0, 0, 1, 1);
        set_exp(1'b1, rb); set_dut(1'b1, ra);
        step("t8.pp", 0, 0, 0, 3'd0, 0, 1, 1, 1);
        rst_i = 1'b1; set_dut(1'b1, rb);
        step("t8.midrst", 0, 0, 0, 3'd0, 0, 0, 0, 0);
        rst_i = 1'b0; clear_inputs();
        step("t8.idle", 0, 0, 0, 3'd0, 0, 0, 0, 1);

        // Streaming run to MAX_COMMITS.
        do_reset("t6.rst");
        for (int i = 0; i <= 600; i++) begin
            if (i < 600) set_exp(1'b1, gen(i)); else set_exp(1'b0, '0);
            if (i > 0)   set_dut(1'b1, gen(i - 1)); else set_dut(1'b0, '0);
            if (i < 600)
                step($sformatf("t6.c%0d", i), 0, 0, 0, 3'd0, 0, i, 1, 1);
            else
                step("t6.max", 1, 1, 0, 3'd0, 0, 600, 0, 0);
        end
        set_dut(1'b1, gen(700));
        step("t6.ignored", 1, 1, 0, 3'd0, 0, 600, 0, 0);
        clear_inputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
